// File: rtl/addr_sequencer_pkg.sv
// Shared types and constants for the test-memory address sequencer.
package addr_sequencer_pkg;

  localparam int DRAIN_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_e;

endpackage

// File: rtl/addr_sequencer_if.sv
// Command/status bundle between the HPS-side controller and the address sequencer.
interface addr_sequencer_if #(
  parameter int ADDR_WIDTH = 11
) ();

  logic                  start;
  logic                  abort;
  logic [ADDR_WIDTH:0]   length;
  logic [ADDR_WIDTH-1:0] addr_out;
  logic                  e_out;
  logic                  busy;
  logic                  done;

  modport master (
    output start, abort, length,
    input  addr_out, e_out, busy, done
  );

  modport slave (
    input  start, abort, length,
    output addr_out, e_out, busy, done
  );

endinterface

// File: rtl/addr_sequencer.sv
// Emits word addresses 0..len-1 with one enable per cycle, waits a drain time,
// then raises a sticky done flag. All outputs are registered.
//
// state    | meaning
// ST_IDLE  | waiting for start; done holds the result of the last run
// ST_RUN   | one strobe per cycle, addr_out counting up to len-1
// ST_DRAIN | strobes finished, waiting for the delay stage to retire
module addr_sequencer
  import addr_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH   = 11,
  parameter int DRAIN_CYCLES = 2
) (
  input logic              pll_clock,
  input logic              reset_n,
  addr_sequencer_if.slave  bus
);

  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(DRAIN_CYCLES);

  seq_state_e              state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   last_q, last_d;
  logic [DRAIN_CNT_W-1:0]  drain_q, drain_d;
  logic                    e_q, e_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    last_d  = last_q;
    drain_d = drain_q;
    e_d     = e_q;
    busy_d  = busy_q;
    done_d  = done_q;

    case (state_q)
      ST_IDLE: begin
        e_d    = 1'b0;
        busy_d = 1'b0;
        if (bus.start && !bus.abort) begin
          if (bus.length == '0) begin
            done_d = 1'b1;
          end else begin
            done_d  = 1'b0;
            // Lengths at or beyond the address space clamp to the full space.
            last_d  = bus.length[ADDR_WIDTH] ? '1
                                             : bus.length[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
            addr_d  = '0;
            e_d     = 1'b1;
            busy_d  = 1'b1;
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (bus.abort) begin
          e_d     = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (addr_q == last_q) begin
          e_d = 1'b0;
          if (DRAIN_CYCLES == 0) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            drain_d = DRAIN_LOAD;
            state_d = ST_DRAIN;
          end
        end else begin
          addr_d = addr_q + ADDR_WIDTH'(1);
        end
      end

      ST_DRAIN: begin
        drain_d = drain_q - DRAIN_CNT_W'(1);
        if (bus.abort) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (drain_q <= DRAIN_CNT_W'(1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: begin
        e_d     = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge pll_clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      last_q  <= '0;
      drain_q <= '0;
      e_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      drain_q <= drain_d;
      e_q     <= e_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.addr_out = addr_q;
  assign bus.e_out    = e_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_addr_sequencer.sv
// Directed bench for addr_sequencer: per-cycle vector table plus full-space runs.
module tb_addr_sequencer;

  localparam int AW = 11;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  addr_sequencer_if #(.ADDR_WIDTH(AW)) bus ();

  addr_sequencer #(
    .ADDR_WIDTH  (AW),
    .DRAIN_CYCLES(2)
  ) dut (
    .pll_clock(clk),
    .reset_n  (rst_n),
    .bus      (bus)
  );

  typedef struct {
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [AW:0]   len;
    logic [AW-1:0] addr;
    logic          e;
    logic          busy;
    logic          done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic s, input logic a, input int l,
                              input int ad, input logic e, input logic b, input logic d);
    vec_t v;
    v.rst_n = r;
    v.start = s;
    v.abort = a;
    v.len   = (AW+1)'(l);
    v.addr  = AW'(ad);
    v.e     = e;
    v.busy  = b;
    v.done  = d;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic long_run(input int len_in, input string nm);
    int  n;
    int  bad;
    int  last_addr;
    bit  ended;
    bit  saw_done;
    bus.start  = 1'b1;
    bus.length = (AW+1)'(len_in);
    tick();
    bus.start = 1'b0;
    n = 0; bad = 0; last_addr = -1; ended = 1'b0; saw_done = 1'b0;
    for (int cyc = 0; cyc < 2100; cyc++) begin
      if (bus.e_out) begin
        if (ended || (bus.addr_out != AW'(n))) bad++;
        last_addr = int'(bus.addr_out);
        n++;
      end else begin
        ended = 1'b1;
      end
      if (bus.done) begin
        saw_done = 1'b1;
        break;
      end
      tick();
    end
    check({nm, " strobes"}, n, 2048);
    check({nm, " last_addr"}, last_addr, 2047);
    check({nm, " seq_errors"}, bad, 0);
    check({nm, " done_seen"}, int'(saw_done), 1);
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    bus.length = '0;

    //                rst s a len  addr e b d
    vecs.push_back(mk(0, 0, 0, 0,    0, 0, 0, 0));
    // length=4 run, done three cycles after the addr=3 strobe
    vecs.push_back(mk(1, 1, 0, 4,    0, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0,    1, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0,    2, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0,    3, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0,    3, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0,    3, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0,    3, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0,    3, 0, 0, 1));
    // length=0: immediate done, no strobe
    vecs.push_back(mk(1, 1, 0, 0,    3, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0,    3, 0, 0, 1));
    // start+abort together in IDLE: nothing happens
    vecs.push_back(mk(1, 1, 1, 4,    3, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0,    3, 0, 0, 1));
    // length=3 with a start mid-run that must be ignored, then reset in DRAIN
    vecs.push_back(mk(1, 1, 0, 3,    0, 1, 1, 0));
    vecs.push_back(mk(1, 1, 0, 9,    1, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0,    2, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0,    2, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,    0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0,    0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0,    0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0,    0, 0, 0, 0));
    // length=16 aborted after the addr=5 strobe, then length=2
    vecs.push_back(mk(1, 1, 0, 16,   0, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0,    1, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0,    2, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0,    3, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0,    4, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0,    5, 1, 1, 0));
    vecs.push_back(mk(1, 0, 1, 0,    5, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0,    5, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 2,    0, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0,    1, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0,    1, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0,    1, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0,    1, 0, 0, 1));
    // length=1 aborted during DRAIN: done stays low
    vecs.push_back(mk(1, 1, 0, 1,    0, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0,    0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 1, 0,    0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0,    0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0,    0, 0, 0, 0));

    tick();
    foreach (vecs[i]) begin
      rst_n      = vecs[i].rst_n;
      bus.start  = vecs[i].start;
      bus.abort  = vecs[i].abort;
      bus.length = vecs[i].len;
      tick();
      check($sformatf("vec%0d {addr,e,busy,done}", i),
            int'({bus.addr_out, bus.e_out, bus.busy, bus.done}),
            int'({vecs[i].addr, vecs[i].e, vecs[i].busy, vecs[i].done}));
    end

    rst_n     = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    tick();
    long_run(2048, "len2048");
    tick();
    long_run(3000, "len3000");
    tick();
    check("post_run idle busy", int'(bus.busy), 0);
    check("post_run done sticky", int'(bus.done), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/addr_sequencer.md
Name: addr_sequencer

Overview:
- Upstream feeder for the address/enable delay stage on the test-memory path, clocked by pll_clock.
- On a start command it emits a contiguous run of word addresses, 0 to length-1, with one enable strobe per cycle.
- It then waits a fixed drain time so the delayed pipeline can retire its last access, and raises a sticky done flag for the HPS/Avalon control logic.
- All outputs are registered, so they drive the delay stage's addr_in/e_in directly.

Parameters:
- ADDR_WIDTH, 11, width of addr_out; address space is 2^ADDR_WIDTH words.
- DRAIN_CYCLES, 2, cycles between the last e_out strobe and done. Covers the downstream delay stage(s) plus the RAM write. Legal range is 0..15.

Ports:
- pll_clock  input  1  sole clock; every register updates on its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  single-cycle command pulse; already synchronous to pll_clock.
- abort  input  1  single-cycle pulse; terminates a run in progress.
- length  input  ADDR_WIDTH+1  number of words to sequence; sampled only when start is accepted.
- addr_out  output  ADDR_WIDTH  current word address; feeds the delay stage's addr_in.
- e_out  output  1  access enable, one per valid address; feeds the delay stage's e_in.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  sticky completion flag.

Behaviour:
- Reset: when reset_n is sampled low, state goes to IDLE and addr_out=0, e_out=0, busy=0, done=0. Reset overrides every other input, including mid-run. No strobe follows reset.
- States: IDLE, RUN, DRAIN.
- IDLE, start=1 and abort=0:
  - Latch len = min(length, 2^ADDR_WIDTH); clear done.
  - If len==0: next cycle done=1, stay IDLE, e_out never asserts.
  - Else: go to RUN. On the next cycle addr_out=0, e_out=1, busy=1. Latency start to first strobe is 1 cycle.
- RUN:
  - Each cycle with e_out=1, addr_out advances by 1.
  - When addr_out==len-1 with e_out=1, the following cycle has e_out=0 and addr_out holds len-1.
  - State then goes to DRAIN with drain counter = DRAIN_CYCLES. If DRAIN_CYCLES==0, go straight to IDLE with done=1.
  - Exactly len strobes, consecutive, no gaps.
- DRAIN: counter decrements each cycle. At 0, state goes to IDLE, busy=0, done=1. done rises DRAIN_CYCLES+1 cycles after the last strobe cycle.
- done: stays 1 in IDLE until the next accepted start, which clears it in the same cycle the latch occurs.
- start while busy: ignored. len is not re-latched and the run is unaffected.
- abort:
  - In RUN or DRAIN: next cycle e_out=0, busy=0, state=IDLE, done stays 0. addr_out holds its last value.
  - In IDLE: no effect.
  - start and abort together in IDLE: abort wins and start is dropped.
- Wrap: len=2^ADDR_WIDTH ends at addr 2^ADDR_WIDTH-1. The counter never wraps to 0 within a run. The internal counter is ADDR_WIDTH+1 bits wide or uses a last-flag compare.
- Every output comes straight from a flop; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package holds:
  - the state enum (IDLE/RUN/DRAIN), 2-bit encoding;
  - DRAIN_CNT_W=4.
- No sub-module needed. The FSM, address counter and drain counter sit in one module of about 150 lines.
- The existing delay stage is instantiated by the parent, not inside this block.

Test Plan:
- Reset, then start with length=4 and DRAIN_CYCLES=2:
  - e_out high for exactly 4 cycles, with addr_out 0,1,2,3, starting 1 cycle after start.
  - done=1 exactly 3 cycles after the addr=3 cycle; busy falls at the same edge.
- start with length=0: no e_out strobe; done=1 on the next cycle; busy stays 0.
- length=2048 (ADDR_WIDTH=11): 2048 consecutive strobes ending at addr 2047, no wrap to 0. length=3000 also gives 2048 strobes.
- Abort after the strobe at addr 5 of a length=16 run:
  - e_out=0 next cycle, busy=0, done=0;
  - a following start length=2 gives addrs 0,1 and then done.
- start pulsed mid-run, and start+abort together in IDLE: the run is unchanged in the first case; nothing starts in the second.
- reset_n low during DRAIN: next cycle all outputs 0, state IDLE, done never asserts.
